jtframe_sdram_arb: RTL and testbench

Round-robin arbiter that shares the single SDRAM read port among the ROM-fetch requesters (main CPU, sound CPU, MCU, ADPCM, graphics). It sits between the per-slot address/chip-select logic and the SDRAM controller. It grants one read at a time and runs the req/ack/data_rdy handshake. It returns the 32-bit word with a one-cycle ok pulse to the owning slot and opens refresh windows when the port is idle.

---
 rtl/jtframe_sdram_arb_pkg.sv | 15 +
 rtl/jtframe_rr_pick.sv | 32 +++
 rtl/jtframe_sdram_arb.sv | 110 +++++++++++
 tb/tb_jtframe_sdram_arb.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_sdram_arb_pkg.sv
// Shared types and default sizing for the SDRAM read-port arbiter.
// Imported by the arbiter top and usable by other jtframe arbiters.
package jtframe_sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        WAIT_DATA
    } arb_state_t;

    localparam int DEF_SLOTS   = 4;
    localparam int DEF_AW      = 22;
    localparam int DEF_TIMEOUT = 63;

endpackage

// File: rtl/jtframe_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// Reusable by any jtframe arbiter that keeps its own pointer register.
module jtframe_rr_pick #(
    parameter int SLOTS = 4,
    parameter int IW    = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
    input  logic [SLOTS-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [SLOTS-1:0] gnt,
    output logic [IW-1:0]    idx,
    output logic             any
);

    logic [IW-1:0] cand;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = 0; k < SLOTS; k++) begin
            cand = IW'((int'(ptr) + k) % SLOTS);
            if (!any && req[cand]) begin
                any       = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jtframe_sdram_arb.sv
// Round-robin owner of the single SDRAM read port: one read in flight at a time,
// req/ack/data_rdy handshake, ok pulse to the owner, refresh window when idle.
module jtframe_sdram_arb
    import jtframe_sdram_arb_pkg::*;
#(
    parameter int SLOTS   = DEF_SLOTS,
    parameter int AW      = DEF_AW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic                downloading,
    input  logic [SLOTS-1:0]    slot_req,
    input  logic [SLOTS*AW-1:0] slot_addr,
    output logic [SLOTS-1:0]    slot_ok,
    output logic [SLOTS-1:0]    slot_gnt,
    output logic [31:0]         slot_data,
    output logic                sdram_req,
    output logic [AW-1:0]       sdram_addr,
    input  logic                sdram_ack,
    input  logic                data_rdy,
    input  logic [31:0]         data_read,
    output logic                refresh_en,
    output logic                timeout_err
);

    localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_t        state, state_nxt;
    logic [IW-1:0]     ptr, owner, ptr_nxt;
    logic [CW-1:0]     cnt;
    logic [SLOTS-1:0]  pick_gnt;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;
    logic              qualify, done, expired;

    jtframe_rr_pick #(.SLOTS(SLOTS), .IW(IW)) u_pick (
        .req (slot_req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Ack and data in the same WAIT_ACK cycle complete the read right away; downloading beats everything.
    assign qualify = !downloading && pick_any;
    assign done    = !downloading && data_rdy &&
                     ((state == WAIT_DATA) || (state == WAIT_ACK && sdram_ack));
    assign expired = !downloading && !data_rdy && (state == WAIT_DATA) &&
                     (cnt == CW'(TIMEOUT - 1));
    assign ptr_nxt = (owner == IW'(SLOTS - 1)) ? '0 : owner + 1'b1;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (qualify) state_nxt = WAIT_ACK;
            WAIT_ACK:  if (downloading || done) state_nxt = IDLE;
                       else if (sdram_ack)      state_nxt = WAIT_DATA;
            WAIT_DATA: if (downloading || done || expired) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sdram_req = (state == WAIT_ACK);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            ptr         <= '0;
            owner       <= '0;
            cnt         <= '0;
            sdram_addr  <= '0;
            slot_gnt    <= '0;
            slot_ok     <= '0;
            slot_data   <= '0;
            refresh_en  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            slot_ok    <= '0;
            refresh_en <= (state == IDLE) && ((slot_req == '0) || downloading);
            cnt        <= (state == WAIT_DATA) ? cnt + 1'b1 : '0;
            if (state == IDLE && qualify) begin
                slot_gnt   <= pick_gnt;
                owner      <= pick_idx;
                sdram_addr <= slot_addr[int'(pick_idx)*AW +: AW];
            end
            if (downloading) slot_gnt <= '0;
            if (done) begin
                slot_data <= data_read;
                slot_ok   <= slot_gnt;
                slot_gnt  <= '0;
                ptr       <= ptr_nxt;
            end
            if (expired) begin
                timeout_err <= 1'b1;
                slot_gnt    <= '0;
                ptr         <= ptr_nxt;
            end
        end
    end

endmodule

// File: tb/tb_jtframe_sdram_arb.sv
// Self-checking bench for jtframe_sdram_arb: a bench-side SDRAM controller model
// drives ack/data, and a scoreboard matches every slot_ok pulse to a pushed expectation.
module tb_jtframe_sdram_arb;

    localparam int SLOTS = 4;
    localparam int AW    = 22;

    typedef struct {
        logic [SLOTS-1:0] ok;
        logic [31:0]      data;
    } exp_t;

    logic                clk;
    logic                rstb;
    logic                downloading;
    logic [SLOTS-1:0]    slot_req;
    logic [SLOTS*AW-1:0] slot_addr;
    logic [SLOTS-1:0]    slot_ok;
    logic [SLOTS-1:0]    slot_gnt;
    logic [31:0]         slot_data;
    logic                sdram_req;
    logic [AW-1:0]       sdram_addr;
    logic                sdram_ack;
    logic                data_rdy;
    logic [31:0]         data_read;
    logic                refresh_en;
    logic                timeout_err;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    logic [AW-1:0] addr_of [SLOTS];
    int   exp_ptr;

    jtframe_sdram_arb #(.SLOTS(SLOTS), .AW(AW), .TIMEOUT(63)) dut (
        .clk         (clk),
        .rstb        (rstb),
        .downloading (downloading),
        .slot_req    (slot_req),
        .slot_addr   (slot_addr),
        .slot_ok     (slot_ok),
        .slot_gnt    (slot_gnt),
        .slot_data   (slot_data),
        .sdram_req   (sdram_req),
        .sdram_addr  (sdram_addr),
        .sdram_ack   (sdram_ack),
        .data_rdy    (data_rdy),
        .data_read   (data_read),
        .refresh_en  (refresh_en),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addrs();
        for (int i = 0; i < SLOTS; i++) slot_addr[i*AW +: AW] = addr_of[i];
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (sdram_req) break;
            tick();
        end
        check({tag, "_req_seen"}, sdram_req, 1);
    endtask

    // One read as seen by the controller: ack after ack_dly cycles, data data_dly cycles after ack (0 = same cycle).
    task automatic xact(input string tag, input int slot, input logic [31:0] d,
                        input int ack_dly, input int data_dly);
        logic [SLOTS-1:0] one;
        one = '0;
        one[slot] = 1'b1;
        wait_req(tag);
        check({tag, "_gnt"}, slot_gnt, one);
        check({tag, "_addr"}, sdram_addr, addr_of[slot]);
        repeat (ack_dly) tick();
        sdram_ack = 1'b1;
        if (data_dly == 0) begin
            data_rdy  = 1'b1;
            data_read = d;
            sb.push_back('{ok: one, data: d});
        end
        tick();
        sdram_ack = 1'b0;
        data_rdy  = 1'b0;
        check({tag, "_req_low"}, sdram_req, 0);
        if (data_dly > 0) begin
            repeat (data_dly - 1) tick();
            data_rdy  = 1'b1;
            data_read = d;
            sb.push_back('{ok: one, data: d});
            tick();
            data_rdy = 1'b0;
        end
        check({tag, "_gnt_clr"}, slot_gnt, 0);
    endtask

    always @(negedge clk) begin
        if (rstb && slot_ok != '0) begin
            if (sb.size() == 0) begin
                check("ok_unexpected", slot_ok, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_ok", slot_ok, e.ok);
                check("sb_data", slot_data, e.data);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rstb        = 1'b0;
        downloading = 1'b0;
        slot_req    = '0;
        sdram_ack   = 1'b0;
        data_rdy    = 1'b0;
        data_read   = '0;
        addr_of[0]  = 22'h000100;
        addr_of[1]  = 22'h011111;
        addr_of[2]  = 22'h012345;
        addr_of[3]  = 22'h3ABCDE;
        set_addrs();
        repeat (3) tick();

        check("rst_req", sdram_req, 0);
        check("rst_addr", sdram_addr, 0);
        check("rst_gnt", slot_gnt, 0);
        check("rst_ok", slot_ok, 0);
        check("rst_data", slot_data, 0);
        check("rst_refresh", refresh_en, 0);
        check("rst_terr", timeout_err, 0);

        rstb = 1'b1;
        tick();
        check("idle_refresh", refresh_en, 1);

        // Single request from slot 2, address changed and request dropped while granted.
        slot_req = 4'b0100;
        tick();
        check("t1_req", sdram_req, 1);
        check("t1_refresh", refresh_en, 0);
        check("t1_gnt", slot_gnt, 4'b0100);
        check("t1_addr", sdram_addr, 22'h012345);
        slot_addr[2*AW +: AW] = 22'h3FFFFF;
        slot_req = '0;
        tick();
        check("t1_req_hold", sdram_req, 1);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        check("t1_req_low", sdram_req, 0);
        check("t1_addr_hold", sdram_addr, 22'h012345);
        repeat (4) tick();
        data_rdy  = 1'b1;
        data_read = 32'hDEADBEEF;
        sb.push_back('{ok: 4'b0100, data: 32'hDEADBEEF});
        tick();
        data_rdy = 1'b0;
        check("t1_ok", slot_ok, 4'b0100);
        check("t1_data", slot_data, 32'hDEADBEEF);
        tick();
        check("t1_ok_pulse", slot_ok, 0);
        check("t1_refresh_back", refresh_en, 1);
        set_addrs();
        exp_ptr = 3;

        // Fairness: everyone requesting, grants must rotate from the pointer.
        slot_req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            xact("fair", exp_ptr, 32'hA000_0000 + i, 1, 2);
            exp_ptr = (exp_ptr + 1) % SLOTS;
        end
        slot_req = '0;
        tick();

        // Ack and data together for slot 1.
        slot_req = 4'b0010;
        xact("same", 1, 32'h1234_5678, 0, 0);
        slot_req = '0;
        exp_ptr = 2;
        tick();

        // Timeout on slot 2, then slot 0 must be next.
        slot_req = 4'b0101;
        wait_req("to");
        check("to_gnt", slot_gnt, 4'b0100);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        repeat (62) tick();
        check("to_err_early", timeout_err, 0);
        check("to_gnt_held", slot_gnt, 4'b0100);
        tick();
        check("to_err", timeout_err, 1);
        check("to_gnt_clr", slot_gnt, 0);
        xact("to_next", 0, 32'hCAFE_0000, 1, 3);
        slot_req = '0;
        exp_ptr = 1;
        tick();

        // Abort while waiting for data; pointer must not move.
        slot_req = 4'b1100;
        wait_req("ab");
        check("ab_gnt", slot_gnt, 4'b0100);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        tick();
        downloading = 1'b1;
        tick();
        check("ab_req", sdram_req, 0);
        check("ab_gnt_clr", slot_gnt, 0);
        data_rdy  = 1'b1;
        data_read = 32'hBAD0_BAD0;
        tick();
        data_rdy = 1'b0;
        check("ab_refresh", refresh_en, 1);
        repeat (3) tick();
        check("ab_no_req", sdram_req, 0);
        downloading = 1'b0;
        xact("resume", 2, 32'h5555_AAAA, 2, 1);
        slot_req = '0;
        tick();
        check("terr_sticky", timeout_err, 1);

        // Reset during WAIT_ACK, then a clean first grant to slot 0.
        slot_req = 4'b1001;
        wait_req("rw");
        check("rw_gnt", slot_gnt, 4'b1000);
        rstb = 1'b0;
        #1;
        check("rw_req", sdram_req, 0);
        check("rw_gnt_clr", slot_gnt, 0);
        check("rw_data", slot_data, 0);
        check("rw_terr", timeout_err, 0);
        check("rw_refresh", refresh_en, 0);
        tick();
        rstb = 1'b1;
        xact("post_rst", 0, 32'h0F0F_F0F0, 1, 1);
        slot_req = '0;
        repeat (3) tick();

        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
